// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the program sequencer: field widths, opcode encodings
// and the control FSM state type.
package seq_ctrl_pkg;

    localparam int unsigned IW  = 18;
    localparam int unsigned AW  = 6;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OpNop        = 4'h0;
    localparam logic [OPW-1:0] OpInc        = 4'h1;
    localparam logic [OPW-1:0] OpDec        = 4'h2;
    localparam logic [OPW-1:0] OpAdd        = 4'h3;
    localparam logic [OPW-1:0] OpSub        = 4'h4;
    localparam logic [OPW-1:0] OpLoad       = 4'h5;
    localparam logic [OPW-1:0] OpStore      = 4'h6;
    localparam logic [OPW-1:0] OpCheck      = 4'h8;
    localparam logic [OPW-1:0] OpSuperCheck = 4'h9;
    localparam logic [OPW-1:0] OpJump       = 4'hA;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLatch,
        StExec,
        StDone
    } state_e;

endpackage

// File: rtl/seq_pc_next.sv
// Combinational next-pc selection and halt detection for the instruction in EXEC.
module seq_pc_next
    import seq_ctrl_pkg::*;
(
    input  logic [AW-1:0] pc,
    input  logic [IW-1:0] op,
    input  logic          flag,
    output logic [AW-1:0] next_pc,
    output logic          halt
);

    logic [OPW-1:0] opcode;
    logic [AW-1:0]  jump_tgt;
    logic [AW-1:0]  check_tgt;
    logic           unused_bits;

    assign opcode      = op[IW-1 -: OPW];
    assign jump_tgt    = op[13:8];
    assign check_tgt   = op[5:0];
    assign unused_bits = ^op[7:6];

    always_comb begin
        next_pc = pc + AW'(1);
        halt    = 1'b0;
        case (opcode)
            OpJump: begin
                next_pc = jump_tgt;
                halt    = (jump_tgt == pc);
            end
            OpCheck, OpSuperCheck: begin
                if (flag) begin
                    next_pc = check_tgt;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_ctrl.sv
// Non-prefetching program sequencer: fetch, latch, execute, one instruction
// per three cycles, with hold stalls, abort and a saturating instruction counter.
module seq_ctrl
    import seq_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic          hold,
    input  logic          flag,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_rdata,
    output logic [IW-1:0] op,
    output logic          exec_en,
    output logic          busy,
    output logic          done,
    output logic [15:0]   instr_count
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [IW-1:0] op_q, op_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [AW-1:0] next_pc;
    logic          halt;

    seq_pc_next u_pc_next (
        .pc      (pc_q),
        .op      (op_q),
        .flag    (flag),
        .next_pc (next_pc),
        .halt    (halt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        exec_en = 1'b0;
        done    = 1'b0;
        if (abort && state_q != StIdle) begin
            // Abort wins over hold and suppresses both exec_en and done.
            state_d = StIdle;
            pc_d    = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    pc_d = '0;
                    if (start && !abort) begin
                        state_d = StFetch;
                        cnt_d   = '0;
                    end
                end
                StFetch: state_d = StLatch;
                StLatch: begin
                    op_d    = imem_rdata;
                    state_d = StExec;
                end
                StExec: begin
                    if (!hold) begin
                        exec_en = 1'b1;
                        pc_d    = next_pc;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        state_d = halt ? StDone : StFetch;
                    end
                end
                StDone: begin
                    done    = 1'b1;
                    pc_d    = '0;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign op          = op_q;
    assign busy        = (state_q != StIdle);
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed timing scenarios plus random
// programs checked against an instruction-level trace model.
module tb_seq_ctrl;
    import seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, abort = 1'b0, hold = 1'b0, flag = 1'b0;
    logic [5:0]  imem_addr;
    logic [17:0] imem_rdata, op;
    logic        exec_en, busy, done;
    logic [15:0] instr_count;
    logic [17:0] mem [64];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    seq_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .hold        (hold),
        .flag        (flag),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .op          (op),
        .exec_en     (exec_en),
        .busy        (busy),
        .done        (done),
        .instr_count (instr_count)
    );

    function automatic logic [17:0] mk(logic [3:0] opc, logic [5:0] a, logic [5:0] b);
        return {opc, a, 2'b00, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_inc();
        for (int i = 0; i < 64; i++) mem[i] = mk(OpInc, 6'd0, 6'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; flag = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        fill_inc();
        rst_n = 1'b0; start = 1'b1; hold = 1'b1; abort = 1'b1;
        tick();
        n_cmp += 6;
        if (op !== 18'd0) begin n_err++; $display("FAIL reset_op: got %0h want 0", op); end
        if (imem_addr !== 6'd0) begin n_err++; $display("FAIL reset_addr: got %0d want 0", imem_addr); end
        if (exec_en !== 1'b0) begin n_err++; $display("FAIL reset_exec: got %b want 0", exec_en); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        if (instr_count !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", instr_count); end
        do_reset();
    endtask

    // Program {0: INC, 1: JUMP->1}: exec at N+3 and N+6, done at N+7, idle at N+8.
    task automatic test_basic_timing();
        fill_inc();
        mem[0] = mk(OpInc, 6'd0, 6'd0);
        mem[1] = mk(OpJump, 6'd1, 6'd0);
        kick();
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_cmp += 3;
            if (exec_en !== (k == 2 || k == 5)) begin
                n_err++; $display("FAIL basic_exec k=%0d: got %b want %b", k, exec_en, (k == 2 || k == 5));
            end
            if (done !== (k == 6)) begin
                n_err++; $display("FAIL basic_done k=%0d: got %b want %b", k, done, (k == 6));
            end
            if (busy !== (k != 7)) begin
                n_err++; $display("FAIL basic_busy k=%0d: got %b want %b", k, busy, (k != 7));
            end
        end
        n_cmp++;
        if (instr_count !== 16'd2) begin n_err++; $display("FAIL basic_cnt: got %0d want 2", instr_count); end
    endtask

    task automatic test_check(input logic f);
        fill_inc();
        mem[0] = mk(OpCheck, 6'd0, 6'd5);
        mem[5] = mk(OpJump, 6'd5, 6'd0);
        flag = f;
        kick();
        tick(); tick(); tick();
        n_cmp++;
        if (imem_addr !== (f ? 6'd5 : 6'd1)) begin
            n_err++; $display("FAIL check_branch flag=%b: got %0d want %0d", f, imem_addr, (f ? 5 : 1));
        end
        do_abort();
        flag = 1'b0;
    endtask

    task automatic test_wrap();
        int  execs = 0;
        bit  seen_done = 0;
        bit  reached = 0;
        fill_inc();
        kick();
        for (int c = 0; c < 400 && !reached; c++) begin
            tick();
            if (done) seen_done = 1;
            if (exec_en) begin
                execs++;
                if (execs == 64) begin
                    n_cmp++;
                    if (imem_addr !== 6'd63) begin n_err++; $display("FAIL wrap_pc63: got %0d want 63", imem_addr); end
                    tick();
                    n_cmp++;
                    if (imem_addr !== 6'd0) begin n_err++; $display("FAIL wrap_addr: got %0d want 0", imem_addr); end
                    reached = 1;
                end
            end
        end
        n_cmp += 2;
        if (!reached) begin n_err++; $display("FAIL wrap_timeout: got %0d execs want 64", execs); end
        if (seen_done) begin n_err++; $display("FAIL wrap_done: got 1 want 0"); end
        do_abort();
    endtask

    task automatic test_hold();
        logic [17:0] w;
        fill_inc();
        w = mk(OpInc, 6'($urandom), 6'($urandom));
        mem[0] = w;
        kick();
        hold = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp += 2;
            if (exec_en !== 1'b0) begin n_err++; $display("FAIL hold_exec k=%0d: got %b want 0", k, exec_en); end
            if (op !== w) begin n_err++; $display("FAIL hold_op k=%0d: got %0h want %0h", k, op, w); end
        end
        hold = 1'b0;
        #1;
        n_cmp++;
        if (exec_en !== 1'b1) begin n_err++; $display("FAIL hold_release: got %b want 1", exec_en); end
        tick();
        n_cmp += 2;
        if (exec_en !== 1'b0) begin n_err++; $display("FAIL hold_single: got %b want 0", exec_en); end
        if (instr_count !== 16'd1) begin n_err++; $display("FAIL hold_cnt: got %0d want 1", instr_count); end
        do_abort();
    endtask

    task automatic test_abort_reset();
        bit seen_done = 0;
        fill_inc();
        kick();
        tick(); tick(); tick(); tick();
        do_abort();
        n_cmp += 3;
        if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (instr_count !== 16'd1) begin n_err++; $display("FAIL abort_cnt: got %0d want 1", instr_count); end
        if (imem_addr !== 6'd0) begin n_err++; $display("FAIL abort_pc: got %0d want 0", imem_addr); end
        for (int k = 0; k < 5; k++) begin
            tick();
            if (done) seen_done = 1;
        end
        n_cmp++;
        if (seen_done) begin n_err++; $display("FAIL abort_done: got 1 want 0"); end
        kick();
        for (int k = 0; k < 7; k++) tick();
        rst_n = 1'b0; abort = 1'b1; start = 1'b1; hold = 1'b1;
        tick();
        n_cmp += 5;
        if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
        if (instr_count !== 16'd0) begin n_err++; $display("FAIL midrst_cnt: got %0d want 0", instr_count); end
        if (op !== 18'd0) begin n_err++; $display("FAIL midrst_op: got %0h want 0", op); end
        if (imem_addr !== 6'd0) begin n_err++; $display("FAIL midrst_addr: got %0d want 0", imem_addr); end
        if (exec_en !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midrst_strobes: got %b%b want 00", exec_en, done);
        end
        do_reset();
    endtask

    // Random programs against an instruction-level trace model, with random stalls.
    task automatic test_random();
        logic [5:0]  pc;
        logic [17:0] w;
        logic [3:0]  opc;
        bit          halted, got_done, finished;
        int          idx;
        int          exp_pc [$];
        for (int run = 0; run < 20; run++) begin
            for (int a = 0; a < 64; a++) begin
                mem[a] = mk(4'($urandom_range(0, 15)), 6'($urandom), 6'($urandom));
                if ($urandom_range(0, 7) == 0) mem[a] = mk(OpJump, 6'(a), 6'($urandom));
            end
            flag = 1'($urandom);
            pc = 6'd0; halted = 0; exp_pc.delete();
            for (int s = 0; s < 30 && !halted; s++) begin
                w = mem[pc];
                opc = w[17:14];
                exp_pc.push_back(int'(pc));
                if (opc == OpJump) begin
                    if (w[13:8] == pc) halted = 1;
                    else pc = w[13:8];
                end else if ((opc == OpCheck || opc == OpSuperCheck) && flag) begin
                    pc = w[5:0];
                end else begin
                    pc = pc + 6'd1;
                end
            end
            kick();
            idx = 0; got_done = 0; finished = 0;
            for (int c = 0; c < 600 && !finished; c++) begin
                tick();
                hold = ($urandom_range(0, 3) == 0);
                #1;
                if (done) begin
                    got_done = 1; finished = 1;
                end else if (exec_en) begin
                    n_cmp++;
                    if (idx >= exp_pc.size() || int'(imem_addr) != exp_pc[idx]) begin
                        n_err++;
                        $display("FAIL rand_pc run=%0d step=%0d: got %0d want %0d", run, idx, imem_addr,
                                 (idx < exp_pc.size()) ? exp_pc[idx] : -1);
                    end
                    idx++;
                    if (!halted && idx == exp_pc.size()) finished = 1;
                end
            end
            hold = 1'b0;
            n_cmp += 2;
            if (got_done !== halted) begin
                n_err++; $display("FAIL rand_halt run=%0d: got %b want %b", run, got_done, halted);
            end
            if (idx != exp_pc.size()) begin
                n_err++; $display("FAIL rand_len run=%0d: got %0d want %0d", run, idx, exp_pc.size());
            end
            if (!halted) do_abort();
            else tick();
            n_cmp++;
            if (busy !== 1'b0) begin n_err++; $display("FAIL rand_idle run=%0d: got %b want 0", run, busy); end
        end
        flag = 1'b0;
    endtask

    // Start pulses while busy must not clear the count; the count saturates.
    task automatic test_start_ignored_saturate();
        int model = 0;
        int cyc = 0;
        fill_inc();
        mem[1] = mk(OpJump, 6'd0, 6'd0);
        kick();
        while (model < 65540 && cyc < 220000) begin
            start = (cyc % 997 == 13);
            tick();
            cyc++;
            if (cyc % 5000 == 0) begin
                n_cmp++;
                if (instr_count !== 16'(model > 65535 ? 65535 : model)) begin
                    n_err++; $display("FAIL busy_start_cnt cyc=%0d: got %0d want %0d", cyc, instr_count, model);
                end
            end
            if (exec_en) model++;
        end
        start = 1'b0;
        tick();
        n_cmp += 2;
        if (model < 65540) begin n_err++; $display("FAIL sat_timeout: got %0d execs want 65540", model); end
        if (instr_count !== 16'hFFFF) begin n_err++; $display("FAIL sat_cnt: got %0h want ffff", instr_count); end
        do_abort();
    endtask

    initial begin
        fill_inc();
        do_reset();
        test_reset();
        test_basic_timing();
        test_check(1'b1);
        test_check(1'b0);
        test_wrap();
        test_hold();
        test_abort_reset();
        test_random();
        test_start_ignored_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
